// File: rtl/dram_pkg.sv
// Shared types for the DRAM row command issuer.
// Address widths, command encodings, policy status and FSM states.
package dram_pkg;

   localparam int ROW_BITS = 16;
   localparam int COL_BITS = 10;

   typedef enum logic [2:0] {
      NOP  = 3'd0,
      ACT  = 3'd1,
      RD   = 3'd2,
      WR   = 3'd3,
      PRE  = 3'd4,
      PREA = 3'd5,
      REF  = 3'd6
   } cmd_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      HIT      = 2'd1,
      MISS     = 2'd2,
      CONFLICT = 2'd3
   } row_stat_t;

   typedef enum logic [3:0] {
      S_IDLE,
      S_QUERY,
      S_PRE,
      S_WAIT_RP,
      S_ACT,
      S_WAIT_RCD,
      S_COL,
      S_WAIT_CCD,
      S_PREA,
      S_WAIT_RPA,
      S_REF,
      S_WAIT_RFC
   } issuer_state_t;

endpackage

// File: rtl/dram_timer.sv
// Load/decrement timing counter, saturating at zero.
// zero_o means the counter holds zero after the coming edge.
module dram_timer #(
   parameter int TIMER_W = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               load_i,
   input  logic [TIMER_W-1:0] load_val_i,
   output logic               zero_o
);

   logic [TIMER_W-1:0] cnt_q;
   logic [TIMER_W-1:0] cnt_d;

   // Next count: load wins, otherwise count down and stick at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_d == '0);

endmodule

// File: rtl/row_cmd_issuer.sv
// Open-row policy initiator: turns one request at a time into
// PRE/ACT/RD/WR sequences and sequences PREA/REF refreshes.
module row_cmd_issuer
   import dram_pkg::*;
#(
   parameter int T_RCD   = 4,
   parameter int T_RP    = 4,
   parameter int T_RFC   = 32,
   parameter int T_CCD   = 2,
   parameter int TIMER_W = 8
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_write,
   input  logic [1:0]          req_bg,
   input  logic [1:0]          req_bank,
   input  logic [ROW_BITS-1:0] req_row,
   input  logic [COL_BITS-1:0] req_col,
   output logic                req_done,
   input  logic                refresh_req,
   output logic                refresh_ack,
   output logic                pol_req_en,
   output logic [1:0]          pol_bg,
   output logic [1:0]          pol_bank,
   output logic [ROW_BITS-1:0] pol_row,
   output logic                pol_row_resolve,
   output logic                pol_refresh,
   input  logic [1:0]          pol_row_stat,
   input  logic [ROW_BITS-1:0] pol_row_conflict,
   input  logic                pol_all_row_closed,
   output logic                cmd_valid,
   output cmd_t                cmd_type,
   output logic [1:0]          cmd_bg,
   output logic [1:0]          cmd_bank,
   output logic [ROW_BITS-1:0] cmd_row,
   output logic [COL_BITS-1:0] cmd_col
);

   localparam logic [TIMER_W-1:0] RCD_LD = TIMER_W'(T_RCD - 1);
   localparam logic [TIMER_W-1:0] RP_LD  = TIMER_W'(T_RP - 1);
   localparam logic [TIMER_W-1:0] RFC_LD = TIMER_W'(T_RFC - 1);
   localparam logic [TIMER_W-1:0] CCD_LD = TIMER_W'(T_CCD - 1);

   issuer_state_t       state_q, state_d;
   logic                write_q;
   logic [1:0]          bg_q, bank_q;
   logic [ROW_BITS-1:0] row_q, conf_q;
   logic [COL_BITS-1:0] col_q;
   logic                tmr_ld;
   logic [TIMER_W-1:0]  tmr_val;
   logic                tmr_zero;

   dram_timer #(.TIMER_W(TIMER_W)) u_timer (
      .clk_i      (CLK),
      .rst_i      (RST),
      .load_i     (tmr_ld),
      .load_val_i (tmr_val),
      .zero_o     (tmr_zero)
   );

   // State register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Latch the accepted request and the conflicting open row.
   always_ff @(posedge CLK) begin
      if (RST) begin
         write_q <= 1'b0;
         bg_q    <= '0;
         bank_q  <= '0;
         row_q   <= '0;
         col_q   <= '0;
         conf_q  <= '0;
      end else begin
         if (req_valid && req_ready) begin
            write_q <= req_write;
            bg_q    <= req_bg;
            bank_q  <= req_bank;
            row_q   <= req_row;
            col_q   <= req_col;
         end
         if (state_q == S_QUERY) begin
            conf_q <= pol_row_conflict;
         end
      end
   end

   // Next state and timer loads; refresh outranks a new request.
   always_comb begin
      state_d = state_q;
      tmr_ld  = 1'b0;
      tmr_val = '0;
      unique case (state_q)
         S_IDLE: begin
            if (refresh_req) begin
               state_d = pol_all_row_closed ? S_REF : S_PREA;
            end else if (req_valid) begin
               state_d = S_QUERY;
            end
         end
         S_QUERY: begin
            case (row_stat_t'(pol_row_stat))
               MISS:     state_d = S_ACT;
               CONFLICT: state_d = S_PRE;
               default:  state_d = S_COL;
            endcase
         end
         S_PRE: begin
            state_d = S_WAIT_RP;
            tmr_ld  = 1'b1;
            tmr_val = RP_LD;
         end
         S_WAIT_RP:  if (tmr_zero) state_d = S_QUERY;
         S_ACT: begin
            state_d = S_WAIT_RCD;
            tmr_ld  = 1'b1;
            tmr_val = RCD_LD;
         end
         S_WAIT_RCD: if (tmr_zero) state_d = S_COL;
         S_COL: begin
            state_d = S_WAIT_CCD;
            tmr_ld  = 1'b1;
            tmr_val = CCD_LD;
         end
         S_WAIT_CCD: if (tmr_zero) state_d = S_IDLE;
         S_PREA: begin
            state_d = S_WAIT_RPA;
            tmr_ld  = 1'b1;
            tmr_val = RP_LD;
         end
         S_WAIT_RPA: if (tmr_zero) state_d = S_REF;
         S_REF: begin
            state_d = S_WAIT_RFC;
            tmr_ld  = 1'b1;
            tmr_val = RFC_LD;
         end
         S_WAIT_RFC: if (tmr_zero) state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   // Moore outputs, all forced quiet while reset is held.
   always_comb begin
      req_ready       = 1'b0;
      req_done        = 1'b0;
      refresh_ack     = 1'b0;
      pol_req_en      = 1'b0;
      pol_bg          = '0;
      pol_bank        = '0;
      pol_row         = '0;
      pol_row_resolve = 1'b0;
      pol_refresh     = 1'b0;
      cmd_valid       = 1'b0;
      cmd_type        = NOP;
      cmd_bg          = '0;
      cmd_bank        = '0;
      cmd_row         = '0;
      cmd_col         = '0;
      if (!RST) begin
         unique case (state_q)
            S_IDLE: req_ready = !refresh_req;
            S_QUERY: begin
               pol_req_en = 1'b1;
               pol_bg     = bg_q;
               pol_bank   = bank_q;
               pol_row    = row_q;
            end
            S_PRE: begin
               pol_req_en      = 1'b1;
               pol_row_resolve = 1'b1;
               pol_bg          = bg_q;
               pol_bank        = bank_q;
               pol_row         = row_q;
               cmd_valid       = 1'b1;
               cmd_type        = PRE;
               cmd_bg          = bg_q;
               cmd_bank        = bank_q;
               cmd_row         = conf_q;
            end
            S_ACT: begin
               cmd_valid = 1'b1;
               cmd_type  = ACT;
               cmd_bg    = bg_q;
               cmd_bank  = bank_q;
               cmd_row   = row_q;
            end
            S_COL: begin
               req_done  = 1'b1;
               cmd_valid = 1'b1;
               cmd_type  = write_q ? WR : RD;
               cmd_bg    = bg_q;
               cmd_bank  = bank_q;
               cmd_row   = row_q;
               cmd_col   = col_q;
            end
            S_PREA: begin
               cmd_valid = 1'b1;
               cmd_type  = PREA;
            end
            S_REF: begin
               cmd_valid   = 1'b1;
               cmd_type    = REF;
               pol_refresh = 1'b1;
            end
            S_WAIT_RFC: refresh_ack = tmr_zero;
            default: ;
         endcase
      end
   end

`ifndef SYNTHESIS
   // A query must never come back with the IDLE status.
   always_ff @(posedge CLK) begin
      if (!RST && state_q == S_QUERY) begin
         assert (pol_row_stat != 2'b00)
            else $error("illegal IDLE row status on query");
      end
   end
`endif

endmodule

// File: tb/tb_row_cmd_issuer.sv
// Directed bench for row_cmd_issuer with a small open-row
// policy model answering queries in the same cycle.
module tb_row_cmd_issuer;
   import dram_pkg::*;

   logic                CLK = 1'b0;
   logic                RST = 1'b1;
   logic                req_valid = 1'b0;
   logic                req_ready;
   logic                req_write = 1'b0;
   logic [1:0]          req_bg = '0;
   logic [1:0]          req_bank = '0;
   logic [ROW_BITS-1:0] req_row = '0;
   logic [COL_BITS-1:0] req_col = '0;
   logic                req_done;
   logic                refresh_req = 1'b0;
   logic                refresh_ack;
   logic                pol_req_en;
   logic [1:0]          pol_bg;
   logic [1:0]          pol_bank;
   logic [ROW_BITS-1:0] pol_row;
   logic                pol_row_resolve;
   logic                pol_refresh;
   logic [1:0]          pol_row_stat;
   logic [ROW_BITS-1:0] pol_row_conflict;
   logic                pol_all_row_closed;
   logic                cmd_valid;
   cmd_t                cmd_type;
   logic [1:0]          cmd_bg;
   logic [1:0]          cmd_bank;
   logic [ROW_BITS-1:0] cmd_row;
   logic [COL_BITS-1:0] cmd_col;

   row_cmd_issuer dut (
      .CLK                (CLK),
      .RST                (RST),
      .req_valid          (req_valid),
      .req_ready          (req_ready),
      .req_write          (req_write),
      .req_bg             (req_bg),
      .req_bank           (req_bank),
      .req_row            (req_row),
      .req_col            (req_col),
      .req_done           (req_done),
      .refresh_req        (refresh_req),
      .refresh_ack        (refresh_ack),
      .pol_req_en         (pol_req_en),
      .pol_bg             (pol_bg),
      .pol_bank           (pol_bank),
      .pol_row            (pol_row),
      .pol_row_resolve    (pol_row_resolve),
      .pol_refresh        (pol_refresh),
      .pol_row_stat       (pol_row_stat),
      .pol_row_conflict   (pol_row_conflict),
      .pol_all_row_closed (pol_all_row_closed),
      .cmd_valid          (cmd_valid),
      .cmd_type           (cmd_type),
      .cmd_bg             (cmd_bg),
      .cmd_bank           (cmd_bank),
      .cmd_row            (cmd_row),
      .cmd_col            (cmd_col)
   );

   always #5 CLK = ~CLK;

   // Policy model: one open-row entry per bank group/bank.
   logic [15:0]         open_v;
   logic [ROW_BITS-1:0] open_row [16];
   logic [3:0]          pidx;

   assign pidx = {pol_bg, pol_bank};
   assign pol_all_row_closed = (open_v == 16'h0);

   always_comb begin
      pol_row_stat     = 2'b10;
      pol_row_conflict = '0;
      if (open_v[pidx]) begin
         if (open_row[pidx] == pol_row) begin
            pol_row_stat = 2'b01;
         end else begin
            pol_row_stat     = 2'b11;
            pol_row_conflict = open_row[pidx];
         end
      end
   end

   always @(posedge CLK) begin
      if (RST || pol_refresh) begin
         open_v <= '0;
      end else if (pol_req_en && pol_row_resolve) begin
         open_v[pidx] <= 1'b0;
      end else if (pol_req_en && pol_row_stat == 2'b10) begin
         open_v[pidx]   <= 1'b1;
         open_row[pidx] <= pol_row;
      end
   end

   int n_err = 0;
   int n_chk = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Per-request event log, cycle 0 = handshake cycle.
   int                  act_c, pre_c, col_c, done_c, rdy_c;
   int                  q1_c, q2_c;
   logic                rdy0, pre_res;
   logic [1:0]          q1_stat, q2_stat;
   logic [ROW_BITS-1:0] act_row, pre_row;
   logic [COL_BITS-1:0] col_col;
   cmd_t                col_type;

   task automatic issue(input logic wr, input logic [1:0] bg,
                        input logic [1:0] bank,
                        input logic [ROW_BITS-1:0] row,
                        input logic [COL_BITS-1:0] col);
      act_c = -1; pre_c = -1; col_c = -1; done_c = -1;
      rdy_c = -1; q1_c = -1; q2_c = -1;
      q1_stat = '0; q2_stat = '0; pre_res = 1'b0;
      act_row = '0; pre_row = '0; col_col = '0;
      col_type = NOP; rdy0 = 1'b0;
      req_write = wr; req_bg = bg; req_bank = bank;
      req_row = row; req_col = col; req_valid = 1'b1;
      for (int c = 0; c < 60; c++) begin
         @(negedge CLK);
         if (c == 0) rdy0 = req_ready;
         if (cmd_valid) begin
            case (cmd_type)
               ACT: begin act_c = c; act_row = cmd_row; end
               PRE: begin
                  pre_c = c; pre_row = cmd_row;
                  pre_res = pol_req_en & pol_row_resolve;
               end
               RD, WR: begin
                  col_c = c; col_type = cmd_type; col_col = cmd_col;
               end
               default: ;
            endcase
         end
         if (pol_req_en && !pol_row_resolve) begin
            if (q1_c < 0) begin
               q1_c = c; q1_stat = pol_row_stat;
            end else begin
               q2_c = c; q2_stat = pol_row_stat;
            end
         end
         if (req_done) done_c = c;
         if (done_c >= 0 && c > done_c && req_ready) begin
            rdy_c = c;
            @(posedge CLK); #1;
            break;
         end
         @(posedge CLK); #1;
         if (c == 0) req_valid = 1'b0;
      end
      req_valid = 1'b0;
   endtask

   int   prea_c, ref_c, ack_c;
   logic rfpol;

   // Refresh log, cycle 0 = first IDLE cycle with refresh_req.
   task automatic do_refresh();
      prea_c = -1; ref_c = -1; ack_c = -1; rfpol = 1'b0;
      rdy0 = 1'b1;
      refresh_req = 1'b1;
      for (int c = 0; c < 100; c++) begin
         @(negedge CLK);
         if (c == 0) rdy0 = req_ready;
         if (cmd_valid && cmd_type == PREA) prea_c = c;
         if (cmd_valid && cmd_type == REF) begin
            ref_c = c; rfpol = pol_refresh;
         end
         if (refresh_ack) ack_c = c;
         @(posedge CLK); #1;
         if (ack_c >= 0) break;
      end
      refresh_req = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   int vsum;

   initial begin
      // Reset state
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("rst_cmd_valid", cmd_valid, 0);
      chk("rst_cmd_type", cmd_type, NOP);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_pol_req_en", pol_req_en, 0);
      @(posedge CLK); #1;
      RST = 1'b0;
      @(negedge CLK);
      chk("rst_ready_after", req_ready, 1);
      @(posedge CLK); #1;

      // Fresh bank: MISS
      issue(1'b0, 2'd1, 2'd2, 16'h001A, 10'h008);
      chk("miss_rdy0", rdy0, 1);
      chk("miss_q1_cyc", q1_c, 1);
      chk("miss_q1_stat", q1_stat, 2'b10);
      chk("miss_pre", pre_c, -1);
      chk("miss_act_cyc", act_c, 2);
      chk("miss_act_row", act_row, 16'h001A);
      chk("miss_rd_cyc", col_c, 6);
      chk("miss_rd_type", col_type, RD);
      chk("miss_rd_col", col_col, 10'h008);
      chk("miss_done_cyc", done_c, 6);
      chk("miss_ready_cyc", rdy_c, 8);

      // Same address: HIT
      issue(1'b0, 2'd1, 2'd2, 16'h001A, 10'h008);
      chk("hit_q1_stat", q1_stat, 2'b01);
      chk("hit_act", act_c, -1);
      chk("hit_pre", pre_c, -1);
      chk("hit_rd_cyc", col_c, 2);
      chk("hit_ready_cyc", rdy_c, 4);

      // Same bank, new row: CONFLICT
      issue(1'b1, 2'd1, 2'd2, 16'h002B, 10'h011);
      chk("cf_q1_stat", q1_stat, 2'b11);
      chk("cf_pre_cyc", pre_c, 2);
      chk("cf_pre_row", pre_row, 16'h001A);
      chk("cf_pre_resolve", pre_res, 1);
      chk("cf_q2_cyc", q2_c, 6);
      chk("cf_q2_stat", q2_stat, 2'b10);
      chk("cf_act_cyc", act_c, 7);
      chk("cf_act_row", act_row, 16'h002B);
      chk("cf_wr_cyc", col_c, 11);
      chk("cf_wr_type", col_type, WR);
      chk("cf_wr_col", col_col, 10'h011);

      // Refresh with one row open
      do_refresh();
      chk("rf_ready0", rdy0, 0);
      chk("rf_prea_cyc", prea_c, 1);
      chk("rf_ref_cyc", ref_c, 5);
      chk("rf_pol_refresh", rfpol, 1);
      chk("rf_ack_cyc", ack_c, 36);
      @(negedge CLK);
      chk("rf_idle_ready", req_ready, 1);
      @(posedge CLK); #1;

      // Refresh and request together, all rows closed
      req_write = 1'b0; req_bg = 2'd1; req_bank = 2'd2;
      req_row = 16'h002B; req_col = 10'h004; req_valid = 1'b1;
      do_refresh();
      chk("rr_ready0", rdy0, 0);
      chk("rr_no_prea", prea_c, -1);
      chk("rr_ref_cyc", ref_c, 1);
      chk("rr_ack_cyc", ack_c, 32);
      issue(1'b0, 2'd1, 2'd2, 16'h002B, 10'h004);
      chk("rr_req_rdy0", rdy0, 1);
      chk("rr_q1_stat", q1_stat, 2'b10);
      chk("rr_act_cyc", act_c, 2);
      chk("rr_rd_cyc", col_c, 6);

      // Reset during WAIT_RCD
      req_write = 1'b0; req_bg = 2'd2; req_bank = 2'd0;
      req_row = 16'h0005; req_col = 10'h003; req_valid = 1'b1;
      @(negedge CLK);
      chk("rw_ready0", req_ready, 1);
      @(posedge CLK); #1;
      req_valid = 1'b0;
      @(posedge CLK); #1;
      @(negedge CLK);
      chk("rw_act", cmd_type, ACT);
      @(posedge CLK); #1;
      RST = 1'b1;
      @(negedge CLK);
      chk("rw_rst_valid", cmd_valid, 0);
      chk("rw_rst_ready", req_ready, 0);
      @(posedge CLK); #1;
      RST = 1'b0;
      @(negedge CLK);
      chk("rw_after_valid", cmd_valid, 0);
      chk("rw_after_done", req_done, 0);
      chk("rw_after_ready", req_ready, 1);
      vsum = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge CLK);
         vsum += int'(cmd_valid) + int'(req_done);
      end
      chk("rw_no_rd", vsum, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/row_cmd_issuer.md
Name: row_cmd_issuer

Overview:
Initiator side of the open-row policy interface. It accepts one memory request at a time and queries the policy tracker for HIT, MISS or CONFLICT. It then issues the matching DRAM command sequence (PRE, ACT, RD/WR) while honouring tRP, tRCD and tCCD, and drives row_resolve to close conflicting rows. It also sequences refresh: PREA, then REF, with the policy flush, holding off requests for tRFC. It sits between the request queue and the DRAM command bus.

Parameters:
T_RCD, 4, cycles from ACT to first RD/WR (must be >= 1)
T_RP, 4, cycles from PRE or PREA to next ACT or REF (must be >= 1)
T_RFC, 32, cycles from REF until the block returns to IDLE (must be >= 1)
T_CCD, 2, cycles from a RD/WR until the next request can be accepted (must be >= 1)
TIMER_W, 8, timer width; every T_* value must be < 2**TIMER_W

Ports:
CLK  in  1  clock
RST  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  request accepted when valid & ready
req_write  in  1  1 = WR, 0 = RD
req_bg  in  2  bank group
req_bank  in  2  bank
req_row  in  ROW_BITS  row address
req_col  in  COL_BITS  column address
req_done  out  1  1-cycle pulse in the cycle the RD/WR is issued
refresh_req  in  1  level; held until refresh_ack
refresh_ack  out  1  1-cycle pulse when refresh completes
pol_req_en  out  1  policy query/update strobe
pol_bg  out  2  policy bank group
pol_bank  out  2  policy bank
pol_row  out  ROW_BITS  policy row
pol_row_resolve  out  1  close the entry at pol_bg/pol_bank
pol_refresh  out  1  flush all policy entries
pol_row_stat  in  2  00 IDLE, 01 HIT, 10 MISS, 11 CONFLICT; combinational in the same cycle as pol_req_en
pol_row_conflict  in  ROW_BITS  open row on CONFLICT
pol_all_row_closed  in  1  no open rows
cmd_valid  out  1  command strobe, one cycle per command
cmd_type  out  3  cmd_t
cmd_bg  out  2  command bank group
cmd_bank  out  2  command bank
cmd_row  out  ROW_BITS  command row
cmd_col  out  COL_BITS  command column

Behaviour:
- Reset (synchronous): state = IDLE, timer = 0, request registers cleared. All outputs are 0 and cmd_type = NOP. req_ready goes to 1 in the first cycle after reset deasserts. Reset mid-sequence abandons the sequence without issuing any further command. The integrator resets the policy instance in the same cycle.
- Outputs are Moore outputs from the state and request registers, except req_ready. No pol_* output depends combinationally on pol_row_stat, so no combinational loop through the policy can form.
- IDLE:
  - req_ready = !refresh_req. refresh_req has priority over req_valid.
  - On handshake: latch write/bg/bank/row/col, go to QUERY.
  - If refresh_req: go to PREA when !pol_all_row_closed, otherwise go to REF.
- QUERY (1 cycle): pol_req_en = 1 with the latched bg/bank/row and resolve = 0. Register pol_row_stat and pol_row_conflict.
  - HIT -> COL
  - MISS -> ACT (the policy has already recorded the row as open)
  - CONFLICT -> PRE
  - IDLE (00) -> COL; this value is illegal on a query and is flagged by an assertion.
- PRE (1 cycle):
  - Issue PRE with cmd_row = the registered conflict row.
  - Assert pol_req_en = 1 and pol_row_resolve = 1 with the latched address; the policy invalidates the entry.
  - Load timer = T_RP-1, go to WAIT_RP.
- WAIT_RP: count down. At 0, go to QUERY. The re-query returns MISS.
- ACT (1 cycle): issue ACT, load timer = T_RCD-1, go to WAIT_RCD. WAIT_RCD: at 0, go to COL.
- COL (1 cycle): issue RD or WR with the latched column, pulse req_done, load timer = T_CCD-1, go to WAIT_CCD. WAIT_CCD: at 0, go to IDLE.
- PREA (1 cycle): issue PREA, load timer = T_RP-1, go to WAIT_RPA. At 0, go to REF.
- REF (1 cycle): issue REF with pol_refresh = 1 (flushes the policy), load timer = T_RFC-1, go to WAIT_RFC. At 0: pulse refresh_ack, go to IDLE.
- Spacing rule: a command issued in cycle N has its dependent command in cycle N+T exactly. A wait state with T = 1 lasts one cycle.
- Latency from the handshake cycle (cycle 0) to the RD/WR issue:
  - HIT: 2 cycles
  - MISS: 2 + T_RCD cycles
  - CONFLICT: 3 + T_RP + T_RCD cycles
- The timer decrements saturating at 0 and never wraps.
- A refresh_req that arrives mid-request is serviced after WAIT_CCD, in IDLE.

Decomposition:
- dram_pkg holds:
  - ROW_BITS and COL_BITS
  - cmd_t enum: NOP=0, ACT=1, RD=2, WR=3, PRE=4, PREA=5, REF=6
  - row_stat_t enum: IDLE=0, HIT=1, MISS=2, CONFLICT=3
  - the issuer state enum
- One sub-module, dram_timer: a TIMER_W-bit load/decrement counter with a zero flag.

Test Plan:
- Fresh bank: request bg=1 bank=2 row=0x1A col=0x08 RD with stat MISS -> ACT in cycle 2, RD in cycle 6 (T_RCD=4), req_done in cycle 6, req_ready high again in cycle 8.
- Same address again: stat HIT -> RD in cycle 2, no ACT or PRE issued.
- Same bank with row=0x2B: CONFLICT with conflict row 0x1A -> PRE row 0x1A with pol_row_resolve=1 in cycle 2, re-query in cycle 6 returns MISS, ACT 0x2B in cycle 7, WR in cycle 11.
- refresh_req with one row open -> PREA, REF after 4 cycles with pol_refresh=1, refresh_ack after 32 cycles; the next query on the previous row returns MISS.
- refresh_req and req_valid both high in IDLE -> req_ready=0 and the refresh is serviced first. With all rows closed, REF is issued with no PREA.
- RST asserted in WAIT_RCD -> no RD issued; the next cycle shows cmd_valid=0, req_done=0 and req_ready=1 once RST falls.
